// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states, the
// per-stage stall/flush bundle and the fixed control patterns it emits.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {HZ_RUN, HZ_MDU, HZ_SLEEP} hz_state_t;

  typedef struct packed {
    logic stallF;
    logic stallD;
    logic flushD;
    logic stallC;
    logic flushC;
    logic stallR;
    logic flushR;
  } stall_flush_t;

  // Freeze F/D/C and bubble R: used for mul/div start, MDU and SLEEP.
  localparam stall_flush_t SF_HOLD = '{stallF: 1'b1, stallD: 1'b1, flushD: 1'b0,
                                       stallC: 1'b1, flushC: 1'b0,
                                       stallR: 1'b1 & 1'b0, flushR: 1'b1};
  localparam stall_flush_t SF_MISS = '{stallF: 1'b1, stallD: 1'b1, flushD: 1'b0,
                                       stallC: 1'b1, flushC: 1'b0,
                                       stallR: 1'b1, flushR: 1'b0};
  localparam stall_flush_t SF_EXC  = '{stallF: 1'b0, stallD: 1'b0, flushD: 1'b1,
                                       stallC: 1'b0, flushC: 1'b1,
                                       stallR: 1'b0, flushR: 1'b0};

  function automatic int unsigned timer_width(input int unsigned lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Request/control bundle between the datapath (master) and the hazard
// sequencer (slave).
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             load_use;
  logic             imiss;
  logic             dmiss;
  logic             mdu_start;
  logic             exc_valid;
  logic             eret;
  logic             br_mispred;
  logic             wait_inst;
  logic             int_pending;
  logic             stallF;
  logic             stallD;
  logic             flushD;
  logic             stallC;
  logic             flushC;
  logic             stallR;
  logic             flushR;
  logic             wait_ex;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output load_use, imiss, dmiss, mdu_start, exc_valid, eret, br_mispred,
           wait_inst, int_pending,
    input  stallF, stallD, flushD, stallC, flushC, stallR, flushR, wait_ex,
           stall_cycles
  );

  modport slave (
    input  load_use, imiss, dmiss, mdu_start, exc_valid, eret, br_mispred,
           wait_inst, int_pending,
    output stallF, stallD, flushD, stallC, flushC, stallR, flushR, wait_ex,
           stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl_mdu_timer.sv
// Mul/div hold timer: loads MDU_LAT-1 on start, counts down to zero while
// the sequencer sits in the MDU state.
module hz_mdu_timer
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MDU_LAT = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);
  localparam int unsigned W = timer_width(MDU_LAT);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(MDU_LAT - 1);
    end else if (dec && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the F->D->C->R pipeline. Controls are
// combinational from state and requests; state and the stall counter are registered.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MDU_LAT = 32,
  parameter int unsigned CNT_W   = 32
) (
  input logic             clk,
  input logic             reset,
  pipe_hazard_ctrl_if.slave hz
);
  hz_state_t        state;
  stall_flush_t     sf;
  logic             go_mdu;
  logic             go_sleep;
  logic             mdu_zero;
  logic [CNT_W-1:0] stall_q;

  // RUN-state priority: dmiss > exception/eret > mdu > wait > mispredict > load-use > imiss.
  always_comb begin
    sf       = '0;
    go_mdu   = 1'b0;
    go_sleep = 1'b0;
    case (state)
      HZ_MDU, HZ_SLEEP: sf = SF_HOLD;
      default: begin
        if (hz.dmiss) begin
          sf = SF_MISS;
        end else if (hz.exc_valid || hz.eret) begin
          sf = SF_EXC;
        end else if (hz.mdu_start) begin
          sf     = SF_HOLD;
          go_mdu = 1'b1;
        end else if (hz.wait_inst && !hz.int_pending) begin
          sf       = SF_HOLD;
          go_sleep = 1'b1;
        end else if (hz.br_mispred) begin
          sf.flushD = 1'b1;
        end else if (hz.load_use) begin
          sf.stallF = 1'b1;
          sf.stallD = 1'b1;
          sf.flushC = 1'b1;
        end else if (hz.imiss) begin
          sf.stallF = 1'b1;
          sf.flushD = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= HZ_RUN;
      stall_q <= '0;
    end else begin
      stall_q <= stall_q + CNT_W'(sf.stallC);
      case (state)
        HZ_RUN: begin
          if (go_mdu)        state <= HZ_MDU;
          else if (go_sleep) state <= HZ_SLEEP;
        end
        HZ_MDU:   if (mdu_zero) state <= HZ_RUN;
        HZ_SLEEP: if (hz.int_pending) state <= HZ_RUN;
        default:  state <= HZ_RUN;
      endcase
    end
  end

  hz_mdu_timer #(
    .MDU_LAT(MDU_LAT)
  ) u_mdu_timer (
    .clk  (clk),
    .reset(reset),
    .load (go_mdu),
    .dec  (state == HZ_MDU),
    .zero (mdu_zero)
  );

  assign hz.stallF       = sf.stallF;
  assign hz.stallD       = sf.stallD;
  assign hz.flushD       = sf.flushD;
  assign hz.stallC       = sf.stallC;
  assign hz.flushC       = sf.flushC;
  assign hz.stallR       = sf.stallR;
  assign hz.flushR       = sf.flushR;
  assign hz.wait_ex      = (state == HZ_SLEEP);
  assign hz.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a 4-cycle/8-bit-counter instance and a default
// instance share stimulus and are compared against a rule-level model.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic load_use = 0, imiss = 0, dmiss = 0, mdu_start = 0, exc_valid = 0;
  logic eret = 0, br_mispred = 0, wait_inst = 0, int_pending = 0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(8))  if4 ();
  pipe_hazard_ctrl_if #(.CNT_W(32)) if32 ();

  pipe_hazard_ctrl #(.MDU_LAT(4), .CNT_W(8)) dut4 (.clk(clk), .reset(reset), .hz(if4));
  pipe_hazard_ctrl #(.MDU_LAT(32), .CNT_W(32)) dut32 (.clk(clk), .reset(reset), .hz(if32));

  assign if4.load_use = load_use;     assign if32.load_use = load_use;
  assign if4.imiss = imiss;           assign if32.imiss = imiss;
  assign if4.dmiss = dmiss;           assign if32.dmiss = dmiss;
  assign if4.mdu_start = mdu_start;   assign if32.mdu_start = mdu_start;
  assign if4.exc_valid = exc_valid;   assign if32.exc_valid = exc_valid;
  assign if4.eret = eret;             assign if32.eret = eret;
  assign if4.br_mispred = br_mispred; assign if32.br_mispred = br_mispred;
  assign if4.wait_inst = wait_inst;   assign if32.wait_inst = wait_inst;
  assign if4.int_pending = int_pending; assign if32.int_pending = int_pending;

  // Packed view: {stallF, stallD, flushD, stallC, flushC, stallR, flushR, wait_ex}
  logic [7:0]  obs [2];
  logic [31:0] sc  [2];
  assign obs[0] = {if4.stallF, if4.stallD, if4.flushD, if4.stallC, if4.flushC,
                   if4.stallR, if4.flushR, if4.wait_ex};
  assign obs[1] = {if32.stallF, if32.stallD, if32.flushD, if32.stallC, if32.flushC,
                   if32.stallR, if32.flushR, if32.wait_ex};
  assign sc[0]  = {24'd0, if4.stall_cycles};
  assign sc[1]  = if32.stall_cycles;

  localparam logic [7:0] P_HOLD = 8'hD2, P_SLEEP = 8'hD3, P_MISS = 8'hD4;
  localparam logic [7:0] P_EXC = 8'h28, P_BR = 8'h20, P_LU = 8'hC8, P_IMISS = 8'hA0;

  // Model: remaining mul/div hold cycles, sleep flag, stall count.
  int          lat   [2] = '{4, 32};
  longint      cmask [2] = '{64'hFF, 64'hFFFF_FFFF};
  int          left  [2];
  bit          slp   [2];
  longint      mcnt  [2];

  function automatic logic [7:0] model_out(input int k);
    if (left[k] > 0)                 return P_HOLD;
    if (slp[k])                      return P_SLEEP;
    if (dmiss)                       return P_MISS;
    if (exc_valid || eret)           return P_EXC;
    if (mdu_start)                   return P_HOLD;
    if (wait_inst && !int_pending)   return P_HOLD;
    if (br_mispred)                  return P_BR;
    if (load_use)                    return P_LU;
    if (imiss)                       return P_IMISS;
    return 8'h00;
  endfunction

  task automatic tick();
    logic [7:0] e;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      e = model_out(k);
      if (!reset) begin
        left[k] = 0; slp[k] = 0; mcnt[k] = 0;
      end else begin
        if (left[k] > 0)                          left[k] = left[k] - 1;
        else if (slp[k])                          slp[k] = !int_pending;
        else if (dmiss || exc_valid || eret)      ;
        else if (mdu_start)                       left[k] = lat[k];
        else if (wait_inst && !int_pending)       slp[k] = 1;
        mcnt[k] = (mcnt[k] + longint'(e[4])) & cmask[k];
      end
    end
    #1;
  endtask

  task automatic clear_in();
    load_use = 0; imiss = 0; dmiss = 0; mdu_start = 0; exc_valid = 0;
    eret = 0; br_mispred = 0; wait_inst = 0; int_pending = 0;
  endtask

  task automatic idle(input int n);
    clear_in();
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    clear_in();
    reset = 0;
    tick(); tick();
    reset = 1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== 8'h00) begin
        failures++; $display("FAIL reset_out dut%0d got=%h exp=00", k, obs[k]);
      end
      checks++;
      if (sc[k] !== 32'd0) begin
        failures++; $display("FAIL reset_cnt dut%0d got=%0d exp=0", k, sc[k]);
      end
    end
  endtask

  task automatic test_load_use();
    idle(40);
    load_use = 1;
    @(negedge clk);
    checks++;
    if (obs[0] !== P_LU) begin
      failures++; $display("FAIL load_use dut0 got=%h exp=%h", obs[0], P_LU);
    end
    tick();
    clear_in();
    @(negedge clk);
    checks++;
    if (obs[0] !== 8'h00) begin
      failures++; $display("FAIL load_use_after dut0 got=%h exp=00", obs[0]);
    end
  endtask

  task automatic test_mdu();
    longint base;
    idle(40);
    base = mcnt[0];
    mdu_start = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (obs[0][4] !== (c < 5)) begin
        failures++; $display("FAIL mdu_stallC cyc%0d got=%b exp=%b", c, obs[0][4], c < 5);
      end
      checks++;
      if (obs[1] !== model_out(1)) begin
        failures++; $display("FAIL mdu_dut1 cyc%0d got=%h exp=%h", c, obs[1], model_out(1));
      end
      tick();
      mdu_start = 0;
    end
    @(negedge clk);
    checks++;
    if (sc[0] !== 32'((base + 5) & 64'hFF)) begin
      failures++; $display("FAIL mdu_count got=%0d exp=%0d", sc[0], (base + 5) & 64'hFF);
    end
  endtask

  task automatic test_wait();
    idle(40);
    wait_inst = 1;
    @(negedge clk);
    checks++;
    if (obs[0] !== P_HOLD) begin
      failures++; $display("FAIL wait_issue got=%h exp=%h", obs[0], P_HOLD);
    end
    tick();
    wait_inst = 0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 10) int_pending = 1;
      @(negedge clk);
      checks++;
      if (obs[0] !== P_SLEEP || obs[1] !== P_SLEEP) begin
        failures++; $display("FAIL wait_sleep cyc%0d got=%h/%h exp=%h", c, obs[0], obs[1], P_SLEEP);
      end
      tick();
    end
    int_pending = 0;
    @(negedge clk);
    checks++;
    if (obs[0] !== 8'h00 || obs[1] !== 8'h00) begin
      failures++; $display("FAIL wait_wake got=%h/%h exp=00", obs[0], obs[1]);
    end
  endtask

  task automatic test_dmiss_priority();
    idle(2);
    dmiss = 1; exc_valid = 1; load_use = 1;
    @(negedge clk);
    checks++;
    if (obs[0] !== P_MISS) begin
      failures++; $display("FAIL dmiss_prio got=%h exp=%h", obs[0], P_MISS);
    end
    tick();
    dmiss = 0;
    @(negedge clk);
    checks++;
    if (obs[0] !== P_EXC) begin
      failures++; $display("FAIL dmiss_drop got=%h exp=%h", obs[0], P_EXC);
    end
    tick();
  endtask

  task automatic test_exc_priority();
    idle(2);
    exc_valid = 1; mdu_start = 1; wait_inst = 1;
    @(negedge clk);
    checks++;
    if (obs[0] !== P_EXC || obs[1] !== P_EXC) begin
      failures++; $display("FAIL exc_prio got=%h/%h exp=%h", obs[0], obs[1], P_EXC);
    end
    tick();
    clear_in();
    @(negedge clk);
    checks++;
    if (obs[0] !== 8'h00 || obs[1] !== 8'h00) begin
      failures++; $display("FAIL exc_stay_run got=%h/%h exp=00", obs[0], obs[1]);
    end
  endtask

  task automatic test_wrap();
    longint base;
    idle(2);
    base = mcnt[0];
    dmiss = 1;
    for (int i = 0; i < 300; i++) tick();
    clear_in();
    @(negedge clk);
    checks++;
    if (sc[0] !== 32'((base + 300) & 64'hFF)) begin
      failures++; $display("FAIL wrap8 got=%0d exp=%0d", sc[0], (base + 300) & 64'hFF);
    end
    checks++;
    if (sc[1] !== 32'(mcnt[1])) begin
      failures++; $display("FAIL wrap32 got=%0d exp=%0d", sc[1], mcnt[1]);
    end
  endtask

  task automatic test_reset_mid_mdu();
    idle(40);
    mdu_start = 1;
    tick();
    clear_in();
    for (int i = 0; i < 14; i++) tick();
    reset = 0;
    @(negedge clk);
    checks++;
    if (obs[1] !== P_HOLD) begin
      failures++; $display("FAIL rst_mdu_hold got=%h exp=%h", obs[1], P_HOLD);
    end
    tick();
    reset = 1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (obs[1] !== 8'h00 || obs[0] !== 8'h00) begin
        failures++; $display("FAIL rst_mdu_out cyc%0d got=%h/%h exp=00", c, obs[0], obs[1]);
      end
      checks++;
      if (sc[1] !== 32'd0) begin
        failures++; $display("FAIL rst_mdu_cnt cyc%0d got=%0d exp=0", c, sc[1]);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(199) != 0);
      dmiss       = ($urandom_range(7) == 0);
      exc_valid   = ($urandom_range(15) == 0);
      eret        = ($urandom_range(15) == 0);
      mdu_start   = ($urandom_range(7) == 0);
      wait_inst   = ($urandom_range(9) == 0);
      int_pending = ($urandom_range(2) == 0);
      br_mispred  = ($urandom_range(5) == 0);
      load_use    = ($urandom_range(3) == 0);
      imiss       = ($urandom_range(3) == 0);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== model_out(k)) begin
          failures++; $display("FAIL rand_out dut%0d i=%0d got=%h exp=%h", k, i, obs[k], model_out(k));
        end
        checks++;
        if (sc[k] !== 32'(mcnt[k])) begin
          failures++; $display("FAIL rand_cnt dut%0d i=%0d got=%0d exp=%0d", k, i, sc[k], mcnt[k]);
        end
        checks++;
        if ((obs[k][6] & obs[k][5]) | (obs[k][4] & obs[k][3]) | (obs[k][2] & obs[k][1])) begin
          failures++; $display("FAIL rand_excl dut%0d i=%0d got=%h exp=no_overlap", k, i, obs[k]);
        end
      end
      tick();
    end
    reset = 1;
    clear_in();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mdu();
    test_wait();
    test_dmiss_priority();
    test_exc_priority();
    test_wrap();
    test_reset_mid_mdu();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
